// File: rtl/bitwise_logic_unit_if.sv
// Valid/ready bus of the bitwise logic unit: request side (operands, opcode,
// accumulator controls) and registered result side.
interface bitwise_logic_unit_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, op, acc_en, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, flag_zero, txn_count
  );

  modport slave (
    input  in_valid, op, acc_en, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, flag_zero, txn_count
  );
endinterface

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise/logical operation unit with valid/ready handshake,
// chaining accumulator and wrapping transaction counter.
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  bitwise_logic_unit_if.slave bus
);

  localparam int unsigned W = WIDTH;
  localparam int unsigned C = CNT_W;

  logic         out_valid_q;
  logic [W-1:0] result_q;
  logic         flag_zero_q;
  logic [C-1:0] txn_count_q;
  logic [W-1:0] acc_q;

  logic         ready_c;
  logic         accept_c;
  logic         transfer_c;
  logic [W-1:0] op_a_c;
  logic [W-1:0] res_c;

  // Full throughput: a held result may be consumed and replaced in one cycle.
  assign ready_c    = !out_valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && ready_c;
  assign transfer_c = out_valid_q && bus.out_ready;

  // A same-cycle clear takes priority over the stale accumulator value.
  assign op_a_c = bus.acc_en ? (bus.acc_clr ? '0 : acc_q) : bus.a;

  always_comb begin
    res_c = '0;
    case (bus.op)
      3'b000:  res_c = op_a_c & bus.b;
      3'b001:  res_c = op_a_c | bus.b;
      3'b010:  res_c = ~op_a_c;
      3'b011:  res_c = op_a_c ^ bus.b;
      3'b100:  res_c = ~(op_a_c ^ bus.b);
      3'b101:  res_c = W'((op_a_c != '0) && (bus.b != '0));
      3'b110:  res_c = W'((op_a_c != '0) || (bus.b != '0));
      3'b111:  res_c = W'(op_a_c == '0);
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_zero_q <= 1'b1;
      txn_count_q <= '0;
      acc_q       <= '0;
    end else begin
      if (accept_c) begin
        out_valid_q <= 1'b1;
        result_q    <= res_c;
        flag_zero_q <= (res_c == '0);
        txn_count_q <= txn_count_q + C'(1);
        acc_q       <= res_c;
      end else begin
        if (transfer_c) out_valid_q <= 1'b0;
        if (bus.acc_clr) acc_q <= '0;
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_zero = flag_zero_q;
  assign bus.txn_count = txn_count_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit; a CNT_W=2 copy receives the same
// stimulus so counter wrap can be observed alongside the main instance.
module tb_bitwise_logic_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bitwise_logic_unit_if #(.WIDTH(4), .CNT_W(8)) bus ();
  bitwise_logic_unit_if #(.WIDTH(4), .CNT_W(2)) bus_w ();

  bitwise_logic_unit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bitwise_logic_unit #(.WIDTH(4), .CNT_W(2)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] o, input logic [3:0] av,
                     input logic [3:0] bv, input logic ae, input logic ac,
                     input logic ordy);
    bus.in_valid = v;    bus_w.in_valid = v;
    bus.op = o;          bus_w.op = o;
    bus.a = av;          bus_w.a = av;
    bus.b = bv;          bus_w.b = bv;
    bus.acc_en = ae;     bus_w.acc_en = ae;
    bus.acc_clr = ac;    bus_w.acc_clr = ac;
    bus.out_ready = ordy; bus_w.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [3:0] res,
                            input logic fz);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".result"},    32'(bus.result),    32'(res));
    chk({tag, ".flag_zero"}, 32'(bus.flag_zero), 32'(fz));
  endtask

  logic [3:0] exp_res [8];
  logic [1:0] exp_wrap [8];

  initial begin
    total = 0;
    bad   = 0;
    exp_res  = '{4'b1000, 4'b1110, 4'b0011, 4'b0110, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0;
    drv(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state
    expect_out("reset", 1'b0, 4'b0000, 1'b1);
    chk("reset.txn_count", 32'(bus.txn_count), 32'd0);
    chk("reset.in_ready",  32'(bus.in_ready),  32'd1);

    // All eight opcodes back-to-back on a=1100, b=1010
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 3'(i), 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b1);
      #1;
      chk($sformatf("op%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      expect_out($sformatf("op%0d", i), 1'b1, exp_res[i], (i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("op%0d.wrap_count", i), 32'(bus_w.txn_count), 32'(exp_wrap[i]));
    end
    chk("ops.txn_count", 32'(bus.txn_count), 32'd8);

    // Backpressure: AND(1111,0101) then stall three cycles
    drv(1'b1, 3'b000, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("bp.and", 1'b1, 4'b0101, 1'b0);
    drv(1'b1, 3'b001, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      tick();
      expect_out($sformatf("bp%0d", i), 1'b1, 4'b0101, 1'b0);
      chk($sformatf("bp%0d.txn_count", i), 32'(bus.txn_count), 32'd9);
    end
    bus.out_ready = 1'b1; bus_w.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    expect_out("bp.release", 1'b1, 4'b0011, 1'b0);
    chk("bp.release.txn_count", 32'(bus.txn_count), 32'd10);

    // Accumulate chain
    drv(1'b1, 3'b011, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("acc.xor", 1'b1, 4'b0110, 1'b0);
    drv(1'b1, 3'b011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("acc.xor_acc", 1'b1, 4'b1001, 1'b0);
    drv(1'b1, 3'b010, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("acc.not_acc", 1'b1, 4'b0110, 1'b0);

    // acc_clr together with accept
    drv(1'b1, 3'b011, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("clr.setup", 1'b1, 4'b1001, 1'b0);
    drv(1'b1, 3'b001, 4'b1111, 4'b0100, 1'b1, 1'b1, 1'b1);
    tick();
    expect_out("clr.or", 1'b1, 4'b0100, 1'b0);
    drv(1'b1, 3'b011, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("clr.acc_loaded", 1'b1, 4'b0100, 1'b0);

    // acc_clr alone, then AND through the accumulator
    drv(1'b0, 3'b000, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1);
    tick();
    expect_out("clr.alone", 1'b0, 4'b0100, 1'b0);
    drv(1'b1, 3'b000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("clr.and_acc", 1'b1, 4'b0000, 1'b1);
    chk("clr.txn_count", 32'(bus.txn_count), 32'd17);

    // Async reset while a result is stalled
    drv(1'b1, 3'b001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("rst.pending", 1'b1, 4'b0001, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 1'b0, 4'b0000, 1'b1);
    chk("rst.async.txn_count", 32'(bus.txn_count), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst.after.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.after.out_valid", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
Parametrised, registered bitwise/logical operation unit with a valid/ready handshake on input and output. It performs one of eight bitwise or logical operations on two WIDTH-bit operands per accepted transaction. An accumulator lets the previous result replace operand A, so operations can be chained. It also keeps a transaction counter. It serves as the lab-datapath successor to the purely combinational operator demo.

Parameters:
WIDTH, 4, operand/result width in bits (>= 1)
CNT_W, 8, width of the transaction counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has a transaction
in_ready  output  1  unit can accept a transaction this cycle
op  input  3  operation select, sampled on accept
acc_en  input  1  operand A := accumulator instead of a, sampled on accept
acc_clr  input  1  synchronous accumulator clear
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream consumes result
result  output  WIDTH  registered result
flag_zero  output  1  result == 0, registered with result
txn_count  output  CNT_W  number of accepted transactions, wraps

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low. There is a single clock domain.
- Reset values:
  - out_valid=0, result=0, flag_zero=1, txn_count=0.
  - Accumulator=0.
  - in_ready=1 (combinational, after reset).
- Handshake:
  - accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational). A new transaction is accepted in the same cycle the held result is consumed, giving full throughput.
  - Latency: 1 cycle. A result accepted at edge N is visible with out_valid=1 after edge N.
- out_valid next state:
  - accept -> 1.
  - else transfer -> 0.
  - else hold.
- While out_valid=1 and out_ready=0: result, flag_zero and out_valid hold stable. in_ready=0, and inputs are ignored.
- Operand A (opA) = acc_en ? acc : a. If acc_clr=1 in the same cycle, opA uses 0 in place of acc.
- Opcode map (the result is computed on opA and b; WIDTH bits):
  - 000 AND: opA & b
  - 001 OR: opA | b
  - 010 NOT: ~opA (b ignored)
  - 011 XOR: opA ^ b
  - 100 XNOR: ~(opA ^ b)
  - 101 LAND: (opA != 0) && (b != 0), zero-extended to WIDTH
  - 110 LOR: (opA != 0) || (b != 0), zero-extended
  - 111 LNOT: (opA == 0), zero-extended (b ignored)
- flag_zero is registered with result on accept: flag_zero = (new result == 0).
- Accumulator:
  - On accept, acc <= new result, regardless of acc_en.
  - Else if acc_clr, acc <= 0.
  - Else hold.
  - acc_clr together with accept: the operand uses 0, and acc then loads the new result.
  - acc_clr without accept: clears acc only; result/out_valid are unaffected.
- txn_count: increments by 1 on each accept. It wraps from 2^CNT_W-1 to 0 and is not cleared by acc_clr.
- Reset mid-operation: all state returns to reset values immediately. A pending result is discarded, not delivered.
- No X propagation: op, a, b and acc_en are only used when accept=1.

Test Plan:
- WIDTH=4, out_ready=1, a=4'b1100, b=4'b1010, ops 000..111 back-to-back, one per cycle -> results 1000, 1110, 0011, 0110, 1001, 0001, 0001, 0000 one cycle after each accept. in_ready stays 1, out_valid stays 1 from the first result onward, flag_zero=1 only for LNOT, and txn_count=8.
- Backpressure: accept AND(1111,0101), then hold out_ready=0 for 3 cycles with in_valid=1 and a different a/b -> result stays 0101, in_ready=0, and txn_count does not advance. Raising out_ready gives transfer and accept in the same cycle.
- Accumulate chain: XOR a=0011,b=0101 -> 0110; then acc_en=1, op=XOR, b=1111 -> 1001; then acc_en=1, op=NOT -> 0110.
- acc_clr with accept: acc=1001, acc_clr=1, acc_en=1, op=OR, b=0100 -> result 0100 and acc=0100. acc_clr alone then acc_en AND b=1111 -> 0000 and flag_zero=1.
- Counter wrap: CNT_W=2, 5 accepts -> txn_count sequence 1,2,3,0,1.
- Async reset: assert rst_n=0 between clock edges while out_valid=1 and out_ready=0 -> out_valid, result and txn_count go to 0 immediately. flag_zero=1, and in_ready=1 after deassertion.
